// File: rtl/fp_add_pipe_if.sv
// Operand/result bundle for the pipelined FP adder. The bench drives through 'master'.
// The adder connects as 'slave'.
interface fp_add_pipe_if #(
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned FRAC_W = 15
);
  logic              in_valid;
  logic              op_sub;
  logic              sign_a;
  logic              sign_b;
  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic [FRAC_W-1:0] frac_a;
  logic [FRAC_W-1:0] frac_b;
  logic              zero_a;
  logic              zero_b;

  logic              out_valid;
  logic              sign_c;
  logic [EXP_W-1:0]  exp_c;
  logic [FRAC_W-1:0] frac_c;
  logic              zero_c;
  logic              ovf;
  logic              udf;

  modport master (
    output in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, zero_a, zero_b,
    input  out_valid, sign_c, exp_c, frac_c, zero_c, ovf, udf
  );

  modport slave (
    input  in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, zero_a, zero_b,
    output out_valid, sign_c, exp_c, frac_c, zero_c, ovf, udf
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Fully pipelined FP add/subtract on unpacked sign/exp/frac operands with RNE rounding.
// An operand set captured at edge N produces its result at edge N+6.
module fp_add_pipe #(
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned FRAC_W = 15
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_pipe_if.slave bus
);

  localparam int unsigned MW  = FRAC_W + 3;  // mantissa plus guard/round/sticky
  localparam int unsigned SW  = FRAC_W + 4;  // adder width with carry
  localparam int unsigned XW  = EXP_W + 2;   // widened signed exponent
  localparam int unsigned LZW = $clog2(MW + 1);
  localparam int EMAX = (1 << (EXP_W - 1)) - 1;
  localparam int EMIN = -(1 << (EXP_W - 1));
  localparam logic [EXP_W:0]         DMAX    = (EXP_W + 1)'(MW);
  localparam logic signed [XW-1:0]   EXP_MAX = XW'(EMAX);
  localparam logic signed [XW-1:0]   EXP_MIN = XW'(EMIN);

  typedef struct packed {
    logic              op_sub;
    logic              sign_a;
    logic              sign_b;
    logic              zero_a;
    logic              zero_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;
  } s0_t;

  typedef struct packed {
    logic              sign;
    logic              eff_sub;
    logic              bz;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] big;
    logic [FRAC_W-1:0] sml;
    logic [EXP_W:0]    diff;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic             bz;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    big;
    logic [MW-1:0]    sml;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic             bz;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
  } s3_t;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          bz;
    logic [XW-1:0] exp;
    logic [MW-1:0] man;
  } s4_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              bz;
    logic [XW-1:0]     exp;
    logic [FRAC_W-1:0] frac;
  } s5_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              ovf;
    logic              udf;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } s6_t;

  s0_t s0_d, s0_q;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  s5_t s5_d, s5_q;
  s6_t s6_d, s6_q;
  logic [6:0] vld_d, vld_q;

  logic              sb_eff, a_ge_b, big_a, both_zero;
  logic [FRAC_W-1:0] fa_m, fb_m;
  logic [EXP_W-1:0]  exp_big, exp_sml;
  logic [EXP_W:0]    sh_amt;
  logic [MW-1:0]     sml_ext, sml_shr;
  logic              sml_lost;
  logic [LZW-1:0]    lzc;
  logic              lz_hit;
  logic [XW-1:0]     exp_wide;
  logic              rnd_up;
  logic [FRAC_W:0]   rnd;

  assign vld_d = {vld_q[5:0], bus.in_valid};

  always_comb begin
    s0_d        = '0;
    s0_d.op_sub = bus.op_sub;
    s0_d.sign_a = bus.sign_a;
    s0_d.sign_b = bus.sign_b;
    s0_d.zero_a = bus.zero_a;
    s0_d.zero_b = bus.zero_b;
    s0_d.exp_a  = bus.exp_a;
    s0_d.exp_b  = bus.exp_b;
    s0_d.frac_a = bus.frac_a;
    s0_d.frac_b = bus.frac_b;
  end

  // S1: order by magnitude; a zero operand always lands in the small slot with frac 0.
  assign sb_eff    = s0_q.sign_b ^ s0_q.op_sub;
  assign a_ge_b    = ($signed(s0_q.exp_a) > $signed(s0_q.exp_b)) ||
                     ((s0_q.exp_a == s0_q.exp_b) && (s0_q.frac_a >= s0_q.frac_b));
  assign big_a     = s0_q.zero_b | (~s0_q.zero_a & a_ge_b);
  assign both_zero = s0_q.zero_a & s0_q.zero_b;
  assign fa_m      = s0_q.zero_a ? '0 : s0_q.frac_a;
  assign fb_m      = s0_q.zero_b ? '0 : s0_q.frac_b;
  assign exp_big   = big_a ? s0_q.exp_a : s0_q.exp_b;
  assign exp_sml   = big_a ? s0_q.exp_b : s0_q.exp_a;

  always_comb begin
    s1_d         = '0;
    s1_d.bz      = both_zero;
    s1_d.eff_sub = s0_q.sign_a ^ sb_eff;
    s1_d.sign    = both_zero ? (s0_q.sign_a & sb_eff) : (big_a ? s0_q.sign_a : sb_eff);
    s1_d.exp     = exp_big;
    s1_d.big     = big_a ? fa_m : fb_m;
    s1_d.sml     = big_a ? fb_m : fa_m;
    s1_d.diff    = (s0_q.zero_a | s0_q.zero_b) ? '0 :
                   ({exp_big[EXP_W-1], exp_big} - {exp_sml[EXP_W-1], exp_sml});
  end

  // S2: align the small operand; everything shifted past the sticky slot ORs into it.
  assign sh_amt   = (s1_q.diff > DMAX) ? DMAX : s1_q.diff;
  assign sml_ext  = {s1_q.sml, 3'b000};
  assign sml_shr  = sml_ext >> sh_amt;
  assign sml_lost = |(sml_ext & ~({MW{1'b1}} << sh_amt));

  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.bz      = s1_q.bz;
    s2_d.exp     = s1_q.exp;
    s2_d.big     = {s1_q.big, 3'b000};
    s2_d.sml     = {sml_shr[MW-1:1], sml_shr[0] | sml_lost};
  end

  // S3: big >= small, so the difference never goes negative.
  always_comb begin
    s3_d      = '0;
    s3_d.sign = s2_q.sign;
    s3_d.bz   = s2_q.bz;
    s3_d.exp  = s2_q.exp;
    s3_d.sum  = s2_q.eff_sub ? ({1'b0, s2_q.big} - {1'b0, s2_q.sml}) :
                               ({1'b0, s2_q.big} + {1'b0, s2_q.sml});
  end

  // S4: normalise.
  always_comb begin
    lzc    = '0;
    lz_hit = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!lz_hit) begin
        if (s3_q.sum[i]) lz_hit = 1'b1;
        else             lzc    = lzc + LZW'(1);
      end
    end
  end

  assign exp_wide = {{2{s3_q.exp[EXP_W-1]}}, s3_q.exp};

  always_comb begin
    s4_d      = '0;
    s4_d.sign = s3_q.sign;
    s4_d.bz   = s3_q.bz;
    s4_d.zero = ~|s3_q.sum;
    if (s3_q.sum[SW-1]) begin
      s4_d.man = {s3_q.sum[SW-1:2], s3_q.sum[1] | s3_q.sum[0]};
      s4_d.exp = exp_wide + XW'(1);
    end else begin
      s4_d.man = s3_q.sum[MW-1:0] << lzc;
      s4_d.exp = exp_wide - XW'(lzc);
    end
  end

  // S5: round to nearest even on guard/round/sticky.
  assign rnd_up = s4_q.man[2] & (s4_q.man[1] | s4_q.man[0] | s4_q.man[3]);
  assign rnd    = {1'b0, s4_q.man[MW-1:3]} + (FRAC_W + 1)'(rnd_up);

  always_comb begin
    s5_d      = '0;
    s5_d.sign = s4_q.sign;
    s5_d.zero = s4_q.zero;
    s5_d.bz   = s4_q.bz;
    if (rnd[FRAC_W]) begin
      s5_d.frac = rnd[FRAC_W:1];
      s5_d.exp  = s4_q.exp + XW'(1);
    end else begin
      s5_d.frac = rnd[FRAC_W-1:0];
      s5_d.exp  = s4_q.exp;
    end
  end

  // S6: exact zero beats range checks; only a both-zero input keeps a negative sign on zero.
  always_comb begin
    s6_d      = '0;
    s6_d.sign = s5_q.sign;
    if (s5_q.zero) begin
      s6_d.zero = 1'b1;
      s6_d.sign = s5_q.bz & s5_q.sign;
    end else if ($signed(s5_q.exp) > EXP_MAX) begin
      s6_d.ovf  = 1'b1;
      s6_d.exp  = EXP_MAX[EXP_W-1:0];
      s6_d.frac = '1;
    end else if ($signed(s5_q.exp) < EXP_MIN) begin
      s6_d.udf  = 1'b1;
      s6_d.zero = 1'b1;
    end else begin
      s6_d.exp  = s5_q.exp[EXP_W-1:0];
      s6_d.frac = s5_q.frac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s4_q  <= '0;
      s5_q  <= '0;
      s6_q  <= '0;
    end else begin
      vld_q <= vld_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      s4_q  <= s4_d;
      s5_q  <= s5_d;
      s6_q  <= s6_d;
    end
  end

  assign bus.out_valid = vld_q[6];
  assign bus.sign_c    = s6_q.sign;
  assign bus.exp_c     = s6_q.exp;
  assign bus.frac_c    = s6_q.frac;
  assign bus.zero_c    = s6_q.zero;
  assign bus.ovf       = s6_q.ovf;
  assign bus.udf       = s6_q.udf;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed and streamed checks of fp_add_pipe at EXP_W=7, FRAC_W=15.
// Streamed expectations come from an exact wide-integer reference.
module tb_fp_add_pipe;
  localparam int unsigned EW = 7;
  localparam int unsigned FW = 15;

  // {out_valid, sign_c, exp_c, frac_c, zero_c, ovf, udf}
  typedef logic [EW+FW+4:0] res_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_miss;

  fp_add_pipe_if #(.EXP_W(EW), .FRAC_W(FW)) bus ();

  fp_add_pipe #(.EXP_W(EW), .FRAC_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t pk(input logic v, input logic s, input logic [EW-1:0] e,
                              input logic [FW-1:0] f, input logic z, input logic o,
                              input logic u);
    return {v, s, e, f, z, o, u};
  endfunction

  function automatic res_t obs();
    return {bus.out_valid, bus.sign_c, bus.exp_c, bus.frac_c, bus.zero_c, bus.ovf, bus.udf};
  endfunction

  // Exact sum on a common binary scale, then RNE to FW bits.
  function automatic res_t model(input logic op, input logic sa, input logic [EW-1:0] ea,
                                 input logic [FW-1:0] fa, input logic za, input logic sb,
                                 input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                                 input logic zb);
    logic sbe, s;
    int ia, ib, base, e, p, k;
    logic [255:0] va, vb, mag, q, rem, half;
    sbe = sb ^ op;
    if (za && zb) return pk(1'b1, sa & sbe, 7'd0, 15'd0, 1'b1, 1'b0, 1'b0);
    if (za)       return pk(1'b1, sbe, eb, fb, 1'b0, 1'b0, 1'b0);
    if (zb)       return pk(1'b1, sa, ea, fa, 1'b0, 1'b0, 1'b0);
    ia   = int'($signed(ea));
    ib   = int'($signed(eb));
    base = (ia < ib) ? ia : ib;
    va   = 256'(fa) << (ia - base);
    vb   = 256'(fb) << (ib - base);
    if (sa == sbe)    begin mag = va + vb; s = sa;  end
    else if (va >= vb) begin mag = va - vb; s = sa;  end
    else              begin mag = vb - va; s = sbe; end
    if (mag == '0) return pk(1'b1, 1'b0, 7'd0, 15'd0, 1'b1, 1'b0, 1'b0);
    p = 0;
    for (int i = 0; i < 256; i++) if (mag[i]) p = i;
    e = base + p - 14;
    if (p > 14) begin
      k    = p - 14;
      q    = mag >> k;
      rem  = mag & ((256'(1) << k) - 256'(1));
      half = 256'(1) << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 256'(1);
      if (q[15]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (14 - p);
    end
    if (e > 63)  return pk(1'b1, s, 7'h3F, 15'h7FFF, 1'b0, 1'b1, 1'b0);
    if (e < -64) return pk(1'b1, s, 7'd0, 15'd0, 1'b1, 1'b0, 1'b1);
    return pk(1'b1, s, 7'(e), q[14:0], 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input res_t got, input res_t want);
    n_cmp++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic want);
    n_cmp++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic op, input logic sa, input logic [EW-1:0] ea,
                       input logic [FW-1:0] fa, input logic za, input logic sb,
                       input logic [EW-1:0] eb, input logic [FW-1:0] fb, input logic zb);
    bus.in_valid = v;
    bus.op_sub   = op;
    bus.sign_a   = sa;
    bus.exp_a    = ea;
    bus.frac_a   = fa;
    bus.zero_a   = za;
    bus.sign_b   = sb;
    bus.exp_b    = eb;
    bus.frac_b   = fb;
    bus.zero_b   = zb;
  endtask

  // One isolated operation: silent at +5, result at +6, silent again at +7.
  task automatic run_one(input string tag, input logic op, input logic sa,
                         input logic [EW-1:0] ea, input logic [FW-1:0] fa, input logic za,
                         input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                         input logic zb, input res_t want);
    @(negedge clk);
    drive(1'b1, op, sa, ea, fa, za, sb, eb, fb, zb);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_bit({tag, "_early"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk(tag, obs(), want);
    @(negedge clk);
    chk_bit({tag, "_drop"}, bus.out_valid, 1'b0);
  endtask

  res_t            sexp [20];
  logic            r_sa, r_sb, r_op, r_za, r_zb;
  logic [EW-1:0]   r_ea, r_eb;
  logic [FW-1:0]   r_fa, r_fb;
  logic [31:0]     rw0, rw1;

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b1;
    n_cmp  = 0;
    n_miss = 0;
    drive(1'b0, 1'b0, 1'b0, 7'd0, 15'd0, 1'b0, 1'b0, 7'd0, 15'd0, 1'b0);
    #2 rst_n = 1'b0;
    #10;
    chk("reset", obs(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("add_1p1", 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd1, 15'h4000, 1'b0, 1'b0, 1'b0));
    run_one("sub_1m1", 1'b1, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'd0, 1'b1, 1'b0, 1'b0));
    run_one("neg3_p1", 1'b0, 1'b1, 7'd1, 15'h6000, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0,
            pk(1'b1, 1'b1, 7'd1, 15'h4000, 1'b0, 1'b0, 1'b0));
    run_one("tie_even", 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'h71, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 1'b0));
    run_one("tie_odd", 1'b0, 1'b0, 7'd0, 15'h4001, 1'b0, 1'b0, 7'h71, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'h4002, 1'b0, 1'b0, 1'b0));
    run_one("tie_carry", 1'b0, 1'b0, 7'd0, 15'h7FFF, 1'b0, 1'b0, 7'h71, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd1, 15'h4000, 1'b0, 1'b0, 1'b0));
    run_one("sticky_sub", 1'b1, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'h6C, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 1'b0));
    run_one("ovf_pos", 1'b0, 1'b0, 7'h3F, 15'h7FFF, 1'b0, 1'b0, 7'h3F, 15'h7FFF, 1'b0,
            pk(1'b1, 1'b0, 7'h3F, 15'h7FFF, 1'b0, 1'b1, 1'b0));
    run_one("ovf_neg", 1'b0, 1'b1, 7'h3F, 15'h7FFF, 1'b0, 1'b1, 7'h3F, 15'h7FFF, 1'b0,
            pk(1'b1, 1'b1, 7'h3F, 15'h7FFF, 1'b0, 1'b1, 1'b0));
    run_one("udf_pos", 1'b1, 1'b0, 7'h40, 15'h6000, 1'b0, 1'b0, 7'h40, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'd0, 1'b1, 1'b0, 1'b1));
    run_one("udf_neg", 1'b1, 1'b1, 7'h40, 15'h6000, 1'b0, 1'b1, 7'h40, 15'h4000, 1'b0,
            pk(1'b1, 1'b1, 7'd0, 15'd0, 1'b1, 1'b0, 1'b1));
    run_one("zero_a", 1'b1, 1'b0, 7'h22, 15'h5555, 1'b1, 1'b1, 7'd0, 15'h6000, 1'b0,
            pk(1'b1, 1'b0, 7'd0, 15'h6000, 1'b0, 1'b0, 1'b0));
    run_one("zero_b", 1'b0, 1'b1, 7'd1, 15'h5000, 1'b0, 1'b0, 7'h3F, 15'h7FFF, 1'b1,
            pk(1'b1, 1'b1, 7'd1, 15'h5000, 1'b0, 1'b0, 1'b0));
    run_one("neg0_neg0", 1'b0, 1'b1, 7'd5, 15'h4123, 1'b1, 1'b1, 7'h3F, 15'h7FFF, 1'b1,
            pk(1'b1, 1'b1, 7'd0, 15'd0, 1'b1, 1'b0, 1'b0));

    // Back-to-back stream: vector c lands at iteration c+7.
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (c >= 7) chk($sformatf("stream%0d", c - 7), obs(), sexp[c - 7]);
      if (c < 20) begin
        rw0  = $urandom();
        rw1  = $urandom();
        r_op = rw0[0];
        r_sa = rw0[1];
        r_sb = rw0[2];
        r_za = (rw0[5:3] == 3'd0);
        r_zb = (rw0[8:6] == 3'd0);
        if (rw0[11:9] == 3'd0) begin
          r_ea = rw0[18:12];
          r_eb = rw0[25:19];
        end else begin
          r_ea = 7'($urandom_range(20)) - 7'd10;
          r_eb = 7'($urandom_range(20)) - 7'd10;
        end
        r_fa = {1'b1, rw1[13:0]};
        r_fb = {1'b1, rw1[27:14]};
        drive(1'b1, r_op, r_sa, r_ea, r_fa, r_za, r_sb, r_eb, r_fb, r_zb);
        sexp[c] = model(r_op, r_sa, r_ea, r_fa, r_za, r_sb, r_eb, r_fb, r_zb);
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Asynchronous reset while the pipe is full of valid work.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0);
    end
    @(negedge clk);
    chk_bit("pre_reset_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk_bit($sformatf("post_reset_idle%0d", c), bus.out_valid, 1'b0);
    end
    run_one("post_reset", 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0, 1'b0, 7'd0, 15'h4000, 1'b0,
            pk(1'b1, 1'b0, 7'd1, 15'h4000, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, fully pipelined floating-point adder/subtractor for the path-tracer datapath.
- Generalises the fixed-width FP21 adder with:
  - configurable exponent and mantissa widths
  - runtime add/subtract select
  - per-cycle valid tracking
  - explicit zero handling
  - round-to-nearest-even
  - exponent overflow/underflow saturation and flags
- Operands use the unpacked sign/exp/frac form and are accepted every cycle.
- Fixed latency: 6 cycles.

Parameters:
- EXP_W, 7: exponent width. Two's-complement, unbiased; range -2^(EXP_W-1)..2^(EXP_W-1)-1.
- FRAC_W, 15: mantissa width including the explicit leading 1 at bit FRAC_W-1. 1.0 = 1 << (FRAC_W-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid this cycle.
- op_sub  in  1  0: a+b; 1: a-b.
- sign_a, sign_b  in  1  operand signs.
- exp_a, exp_b  in  EXP_W  signed exponents.
- frac_a, frac_b  in  FRAC_W  normalized mantissas; MSB = 1 unless the operand is zero.
- zero_a, zero_b  in  1  operand is zero; its exp/frac are ignored.
- out_valid  out  1  result valid.
- sign_c  out  1  result sign.
- exp_c  out  EXP_W  result exponent.
- frac_c  out  FRAC_W  result mantissa, normalized (MSB = 1) unless zero_c.
- zero_c  out  1  result is zero.
- ovf  out  1  exponent overflow; result saturated.
- udf  out  1  exponent underflow; result flushed to zero.

Behaviour:
- Reset (asynchronous, rst_n low): every pipeline register and every output clears to 0. Pipeline contents are discarded mid-operation. out_valid stays 0 until 6 cycles after the first in_valid sampled after reset release.
- Throughput 1/cycle, no backpressure. The result for an input sampled at edge N appears at edge N+6.
- in_valid is carried down a 6-deep valid chain. Data stages update every cycle regardless of valid. Outputs while out_valid=0 are don't-care, except after reset (all 0).
- S1, effective sign and ordering:
  - sb_eff = sign_b ^ op_sub.
  - Compare magnitudes as the {exp, frac} tuple (signed exp); swap so big >= small.
  - Sign = sign of big; on equal magnitudes, sign of a.
  - diff = exp_big - exp_small, computed in EXP_W+1 bits (unsigned, never negative).
- S2, alignment:
  - Small mantissa is extended with 3 low bits (guard, round, sticky).
  - Shift right by diff, saturating at FRAC_W+3.
  - Every bit shifted out ORs into sticky.
- S3, combine: effective subtract when sign_a != sb_eff. Magnitude add or subtract in FRAC_W+4 bits. The result is always non-negative.
- S4, normalize:
  - On carry out: shift right 1, fold the LSB into sticky, exp+1.
  - Otherwise: leading-zero count, left shift, exp - lzc.
  - Exponent is carried in EXP_W+2 signed bits.
- S5, rounding:
  - RNE: round up when g & (r | s | lsb).
  - If the mantissa rounds to 2^FRAC_W, shift right 1 and exp+1.
- S6, range and zero:
  - Exp > max: ovf=1, exp_c = max, frac_c all ones, sign kept.
  - Exp < min: udf=1, zero_c=1, exp_c=0, frac_c=0, sign kept.
  - Exact zero result of nonzero operands: zero_c=1, sign_c=0, exp_c=0, frac_c=0.
- Zero operands:
  - One zero: result = the other operand, with sb_eff applied if it is b. Exact pass-through, no flags.
  - Both zero: zero_c=1, sign_c = sign_a & sb_eff.
- ovf, udf and zero_c are mutually exclusive and aligned with out_valid.

Test Plan:
- Add 1.0 + 1.0 (exp 0, frac 0x4000 both), in_valid pulse at edge 0 -> edge 6: out_valid=1, exp_c=1, frac_c=0x4000, sign_c=0, no flags. out_valid=0 at edge 7.
- Subtract 1.0 - 1.0 (op_sub=1) -> zero_c=1, sign_c=0, exp_c=0, frac_c=0. Then -3.0 + 1.0 -> sign_c=1, exp_c=1, frac_c=0x4000.
- Rounding ties: 1.0 + 2^-15 (exp -15, frac 0x4000) -> frac_c=0x4000, exp_c=0. Then frac_a=0x4001 + 2^-15 -> frac_c=0x4002. Then 0x7FFF + 2^-15 -> exp_c=1, frac_c=0x4000.
- Range: max + max (exp 63, frac 0x7FFF) -> ovf=1, exp_c=63, frac_c=0x7FFF. Then exp -64 frac 0x6000 minus exp -64 frac 0x4000 -> udf=1, zero_c=1.
- Zeros: zero_a=1 with b = -1.5, op_sub=1 -> sign_c=0, exp_c=0, frac_c=0x6000. Then -0 + -0 -> zero_c=1, sign_c=1.
- Streaming and reset:
  - 20 back-to-back random valid vectors -> each result matches the reference model at exactly +6 cycles.
  - Drop rst_n mid-stream (asynchronously, between edges) -> all outputs 0 immediately.
  - After release, no out_valid until 6 cycles after new input.
